// File: rtl/decoder_pkg.sv
// Shared types and encodings for the instruction-decode stage.
package decoder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CSR_W  = 12;
  localparam int unsigned ALU_W  = 10;
  localparam int unsigned BR_W   = 6;
  localparam int unsigned MEM_W  = 5;
  localparam int unsigned MD_W   = 8;

  // One-hot ALU operation bit indices
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLL  = 2;
  localparam int unsigned ALU_SLT  = 3;
  localparam int unsigned ALU_SLTU = 4;
  localparam int unsigned ALU_XOR  = 5;
  localparam int unsigned ALU_SRL  = 6;
  localparam int unsigned ALU_SRA  = 7;
  localparam int unsigned ALU_OR   = 8;
  localparam int unsigned ALU_AND  = 9;

  // One-hot branch comparison bit indices
  localparam int unsigned BR_EQ  = 0;
  localparam int unsigned BR_NE  = 1;
  localparam int unsigned BR_LT  = 2;
  localparam int unsigned BR_GE  = 3;
  localparam int unsigned BR_LTU = 4;
  localparam int unsigned BR_GEU = 5;

  // One-hot memory access size bit indices
  localparam int unsigned MEM_B  = 0;
  localparam int unsigned MEM_H  = 1;
  localparam int unsigned MEM_W_ = 2;
  localparam int unsigned MEM_BU = 3;
  localparam int unsigned MEM_HU = 4;

  // md_op bit index equals funct3: mul,mulh,mulhsu,mulhu,div,divu,rem,remu

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SR      = 3'b101;

  localparam logic [6:0] F7_ZERO   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [DATA_W-1:0] MRET_INSTR = 32'h3020_0073;

  typedef struct packed {
    logic [ALU_W-1:0]  alu_op;
    logic              src1_pc;
    logic              src1_zero;
    logic              src2_imm;
    logic [BR_W-1:0]   br_op;
    logic              branch;
    logic              jump;
    logic              jalr;
    logic [MEM_W-1:0]  mem_op;
    logic              mem_read;
    logic              mem_write;
    logic [MD_W-1:0]   md_op;
    logic              md_en;
    logic [CSR_W-1:0]  csr_addr;
    logic              csr_read;
    logic              csr_write;
    logic              csr_set;
    logic              csr_clear;
    logic              csr_imm;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic              rd_write;
    logic              mret;
    logic              illegal;
  } dec_ctrl_t;

  // Map OP/OP-IMM funct3 (plus the sub/sra alternate bit) to a one-hot ALU op
  function automatic logic [ALU_W-1:0] alu_sel(input logic [2:0] f3, input logic alt);
    logic [ALU_W-1:0] sel;
    sel = '0;
    case (f3)
      3'b000:  sel[alt ? ALU_SUB : ALU_ADD] = 1'b1;
      3'b001:  sel[ALU_SLL]  = 1'b1;
      3'b010:  sel[ALU_SLT]  = 1'b1;
      3'b011:  sel[ALU_SLTU] = 1'b1;
      3'b100:  sel[ALU_XOR]  = 1'b1;
      3'b101:  sel[alt ? ALU_SRA : ALU_SRL] = 1'b1;
      3'b110:  sel[ALU_OR]   = 1'b1;
      default: sel[ALU_AND]  = 1'b1;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/decoder_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decoder_if;
  import decoder_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  dec_ctrl_t         out_ctrl;
  logic [DATA_W-1:0] out_pc;
  logic [DATA_W-1:0] out_instr;

  // Environment side: fetch producer and execute consumer
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_ctrl, out_pc, out_instr
  );

  // Decode stage side
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_ctrl, out_pc, out_instr
  );
endinterface

// File: rtl/decoder_core.sv
// Combinational RV32I/Zicsr/mret decoder; RV32M is decoded when DECODER_RVM_EN is defined.
module decoder_core
  import decoder_pkg::*;
#(
  parameter bit SUPPORT_ZICSR = 1'b1,
  parameter bit SUPPORT_TRAP  = 1'b1
) (
  input  logic [DATA_W-1:0] instr,
  output dec_ctrl_t         ctrl_c
);

  logic [6:0]        opcode;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic [REG_W-1:0]  rd;
  logic [REG_W-1:0]  rs1;
  logic [REG_W-1:0]  rs2;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_b;
  logic [DATA_W-1:0] imm_u;
  logic [DATA_W-1:0] imm_j;
  logic              bad;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Opcode/funct decode; illegal encodings are stripped of all side effects
  always_comb begin
    ctrl_c     = '0;
    bad        = 1'b0;
    ctrl_c.rd  = rd;
    ctrl_c.rs1 = rs1;
    ctrl_c.rs2 = rs2;
    case (opcode)
      OPC_LUI: begin
        ctrl_c.alu_op[ALU_ADD] = 1'b1;
        ctrl_c.src1_zero       = 1'b1;
        ctrl_c.src2_imm        = 1'b1;
        ctrl_c.imm             = imm_u;
        ctrl_c.rd_write        = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_c.alu_op[ALU_ADD] = 1'b1;
        ctrl_c.src1_pc         = 1'b1;
        ctrl_c.src2_imm        = 1'b1;
        ctrl_c.imm             = imm_u;
        ctrl_c.rd_write        = 1'b1;
      end
      OPC_JAL: begin
        ctrl_c.alu_op[ALU_ADD] = 1'b1;
        ctrl_c.src1_pc         = 1'b1;
        ctrl_c.src2_imm        = 1'b1;
        ctrl_c.jump            = 1'b1;
        ctrl_c.imm             = imm_j;
        ctrl_c.rd_write        = 1'b1;
      end
      OPC_JALR: begin
        ctrl_c.alu_op[ALU_ADD] = 1'b1;
        ctrl_c.src2_imm        = 1'b1;
        ctrl_c.jump            = 1'b1;
        ctrl_c.jalr            = 1'b1;
        ctrl_c.imm             = imm_i;
        ctrl_c.rd_write        = 1'b1;
        bad                    = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        ctrl_c.branch = 1'b1;
        ctrl_c.imm    = imm_b;
        case (funct3)
          3'b000:  ctrl_c.br_op[BR_EQ]  = 1'b1;
          3'b001:  ctrl_c.br_op[BR_NE]  = 1'b1;
          3'b100:  ctrl_c.br_op[BR_LT]  = 1'b1;
          3'b101:  ctrl_c.br_op[BR_GE]  = 1'b1;
          3'b110:  ctrl_c.br_op[BR_LTU] = 1'b1;
          3'b111:  ctrl_c.br_op[BR_GEU] = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl_c.alu_op[ALU_ADD] = 1'b1;
        ctrl_c.src2_imm        = 1'b1;
        ctrl_c.imm             = imm_i;
        ctrl_c.mem_read        = 1'b1;
        ctrl_c.rd_write        = 1'b1;
        case (funct3)
          3'b000:  ctrl_c.mem_op[MEM_B]  = 1'b1;
          3'b001:  ctrl_c.mem_op[MEM_H]  = 1'b1;
          3'b010:  ctrl_c.mem_op[MEM_W_] = 1'b1;
          3'b100:  ctrl_c.mem_op[MEM_BU] = 1'b1;
          3'b101:  ctrl_c.mem_op[MEM_HU] = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl_c.alu_op[ALU_ADD] = 1'b1;
        ctrl_c.src2_imm        = 1'b1;
        ctrl_c.imm             = imm_s;
        ctrl_c.mem_write       = 1'b1;
        case (funct3)
          3'b000:  ctrl_c.mem_op[MEM_B]  = 1'b1;
          3'b001:  ctrl_c.mem_op[MEM_H]  = 1'b1;
          3'b010:  ctrl_c.mem_op[MEM_W_] = 1'b1;
          default: bad = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        ctrl_c.src2_imm = 1'b1;
        ctrl_c.imm      = imm_i;
        ctrl_c.rd_write = 1'b1;
        ctrl_c.alu_op   = alu_sel(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT));
        if ((funct3 == F3_SLL) && (funct7 != F7_ZERO)) bad = 1'b1;
        if ((funct3 == F3_SR) && (funct7 != F7_ZERO) && (funct7 != F7_ALT)) bad = 1'b1;
      end
      OPC_OP: begin
        ctrl_c.rd_write = 1'b1;
        if (funct7 == F7_MULDIV) begin
`ifdef DECODER_RVM_EN
          ctrl_c.md_en = 1'b1;
          ctrl_c.md_op = MD_W'(1) << funct3;
`else
          bad = 1'b1;
`endif
        end else if ((funct7 == F7_ZERO) ||
                     ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SR)))) begin
          ctrl_c.alu_op = alu_sel(funct3, funct7 == F7_ALT);
        end else begin
          bad = 1'b1;
        end
      end
      OPC_MISC_MEM: begin
        // fence is a no-op for an in-order core
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          if (SUPPORT_TRAP && (instr == MRET_INSTR)) ctrl_c.mret = 1'b1;
          else bad = 1'b1;
        end else if (!SUPPORT_ZICSR || (funct3 == 3'b100)) begin
          bad = 1'b1;
        end else begin
          ctrl_c.csr_addr = instr[31:20];
          ctrl_c.csr_imm  = funct3[2];
          ctrl_c.imm      = DATA_W'(rs1);
          case (funct3[1:0])
            2'b01: begin
              ctrl_c.csr_write = 1'b1;
              ctrl_c.csr_read  = (rd != '0);
            end
            2'b10: begin
              ctrl_c.csr_read = 1'b1;
              ctrl_c.csr_set  = (rs1 != '0);
            end
            default: begin
              ctrl_c.csr_read  = 1'b1;
              ctrl_c.csr_clear = (rs1 != '0);
            end
          endcase
          ctrl_c.rd_write = ctrl_c.csr_read;
        end
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      ctrl_c.rd_write  = 1'b0;
      ctrl_c.mem_read  = 1'b0;
      ctrl_c.mem_write = 1'b0;
      ctrl_c.csr_read  = 1'b0;
      ctrl_c.csr_write = 1'b0;
      ctrl_c.csr_set   = 1'b0;
      ctrl_c.csr_clear = 1'b0;
      ctrl_c.branch    = 1'b0;
      ctrl_c.jump      = 1'b0;
      ctrl_c.jalr      = 1'b0;
    end
    ctrl_c.illegal = SUPPORT_TRAP ? bad : 1'b0;
  end

endmodule

// File: rtl/decoder_stage.sv
// Registered decode pipeline stage with 2-entry skid buffer and synchronous flush.
module decoder_stage
  import decoder_pkg::*;
#(
  parameter int unsigned XLEN          = 32,
  parameter bit          SUPPORT_ZICSR = 1'b1,
  parameter bit          SUPPORT_TRAP  = 1'b1
) (
  input  logic      clk,
  input  logic      rst_b,
  input  logic      flush,
  decoder_if.slave  bus
);

  if (XLEN != DATA_W) begin : g_xlen_check
    $error("decoder_stage: only XLEN=32 is supported");
  end

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  state_e            state_q;
  state_e            state_d;
  logic              in_ready_q;
  logic              in_ready_d;
  logic              out_valid_q;
  logic              out_valid_d;
  logic              xfer_in;
  logic              xfer_out;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid;
  dec_ctrl_t         dec_c;
  dec_ctrl_t         main_ctrl_q;
  dec_ctrl_t         skid_ctrl_q;
  logic [DATA_W-1:0] main_pc_q;
  logic [DATA_W-1:0] main_instr_q;
  logic [DATA_W-1:0] skid_pc_q;
  logic [DATA_W-1:0] skid_instr_q;

  decoder_core #(
    .SUPPORT_ZICSR (SUPPORT_ZICSR),
    .SUPPORT_TRAP  (SUPPORT_TRAP)
  ) u_core (
    .instr  (bus.in_instr),
    .ctrl_c (dec_c)
  );

  assign xfer_in  = bus.in_valid & in_ready_q;
  assign xfer_out = out_valid_q & bus.out_ready;

  // Next-state and register-load selection; flush overrides every transition
  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (xfer_in) begin
          state_d    = ST_FULL;
          ld_main_in = 1'b1;
        end
      end
      ST_FULL: begin
        if (xfer_in && !xfer_out) begin
          state_d = ST_SKID;
          ld_skid = 1'b1;
        end else if (xfer_in && xfer_out) begin
          ld_main_in = 1'b1;
        end else if (xfer_out) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (xfer_out) begin
          state_d      = ST_FULL;
          ld_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d      = ST_EMPTY;
      ld_main_in   = 1'b0;
      ld_main_skid = 1'b0;
      ld_skid      = 1'b0;
    end
    in_ready_d  = (state_d != ST_SKID);
    out_valid_d = (state_d != ST_EMPTY);
  end

  // State and handshake flags
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Main and skid payload registers; decode result is captured once at entry
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      main_ctrl_q  <= '0;
      main_pc_q    <= '0;
      main_instr_q <= '0;
      skid_ctrl_q  <= '0;
      skid_pc_q    <= '0;
      skid_instr_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_ctrl_q  <= dec_c;
        main_pc_q    <= bus.in_pc;
        main_instr_q <= bus.in_instr;
      end else if (ld_main_skid) begin
        main_ctrl_q  <= skid_ctrl_q;
        main_pc_q    <= skid_pc_q;
        main_instr_q <= skid_instr_q;
      end
      if (ld_skid) begin
        skid_ctrl_q  <= dec_c;
        skid_pc_q    <= bus.in_pc;
        skid_instr_q <= bus.in_instr;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_pc    = main_pc_q;
  assign bus.out_instr = main_instr_q;

endmodule

// File: tb/tb_decoder_stage.sv
// Directed bench for decoder_stage: decode vectors, skid ordering, flush and reset.
module tb_decoder_stage;
  import decoder_pkg::*;

  logic clk;
  logic rst_b;
  logic flush;
  int   n_checks;
  int   n_fail;

  logic [31:0] imm_q[$];
  logic [31:0] pc_q[$];

  decoder_if bus ();

  decoder_stage dut (
    .clk   (clk),
    .rst_b (rst_b),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every output transfer; inputs only change just after posedge
  always @(negedge clk) begin
    if (rst_b && bus.out_valid && bus.out_ready) begin
      imm_q.push_back(bus.out_ctrl.imm);
      pc_q.push_back(bus.out_pc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] addi_x1(input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, 5'd1, 7'h13};
  endfunction

  // Push one instruction through an idle stage with execute always ready
  task automatic decode_one(input logic [31:0] ins, output dec_ctrl_t c);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = ins;
    bus.in_pc     = 32'h200;
    step();
    bus.in_valid = 1'b0;
    check_eq("dec_vld", 64'(bus.out_valid), 64'd1);
    c = bus.out_ctrl;
    step();
  endtask

  dec_ctrl_t c;

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_b         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;
    step();
    step();
    check_eq("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_eq("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check_eq("rst_out_pc",    64'(bus.out_pc),    64'd0);
    check_eq("rst_out_instr", 64'(bus.out_instr), 64'd0);
    check_eq("rst_out_ctrl",  64'(bus.out_ctrl == '0), 64'd1);
    rst_b = 1'b1;
    step();

    // addi x1,x0,5 with one-cycle latency
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 32'h0050_0093;
    bus.in_pc     = 32'h0000_0010;
    step();
    bus.in_valid = 1'b0;
    check_eq("addi_vld",   64'(bus.out_valid),          64'd1);
    check_eq("addi_alu",   64'(bus.out_ctrl.alu_op),    64'h001);
    check_eq("addi_src2",  64'(bus.out_ctrl.src2_imm),  64'd1);
    check_eq("addi_imm",   64'(bus.out_ctrl.imm),       64'd5);
    check_eq("addi_rd",    64'(bus.out_ctrl.rd),        64'd1);
    check_eq("addi_wr",    64'(bus.out_ctrl.rd_write),  64'd1);
    check_eq("addi_ill",   64'(bus.out_ctrl.illegal),   64'd0);
    check_eq("addi_pc",    64'(bus.out_pc),             64'h10);
    check_eq("addi_instr", 64'(bus.out_instr),          64'h0050_0093);
    step();
    check_eq("addi_drain", 64'(bus.out_valid), 64'd0);

    // mul x3,x1,x2
    decode_one(32'h0220_81b3, c);
    check_eq("mul_rd", 64'(c.rd), 64'd3);
`ifdef DECODER_RVM_EN
    check_eq("mul_md_op", 64'(c.md_op),    64'h01);
    check_eq("mul_md_en", 64'(c.md_en),    64'd1);
    check_eq("mul_wr",    64'(c.rd_write), 64'd1);
    check_eq("mul_alu",   64'(c.alu_op),   64'd0);
    check_eq("mul_ill",   64'(c.illegal),  64'd0);
`else
    check_eq("mul_ill",   64'(c.illegal),  64'd1);
    check_eq("mul_wr",    64'(c.rd_write), 64'd0);
    check_eq("mul_md_en", 64'(c.md_en),    64'd0);
`endif

    // mret legal, ecall illegal
    decode_one(32'h3020_0073, c);
    check_eq("mret_flag", 64'(c.mret),    64'd1);
    check_eq("mret_ill",  64'(c.illegal), 64'd0);
    decode_one(32'h0000_0073, c);
    check_eq("ecall_ill",  64'(c.illegal), 64'd1);
    check_eq("ecall_mret", 64'(c.mret),    64'd0);

    // csrrs a0,mstatus,x0 and csrrw x0,mstatus,x0
    decode_one(32'h3000_2573, c);
    check_eq("csrrs_read", 64'(c.csr_read), 64'd1);
    check_eq("csrrs_set",  64'(c.csr_set),  64'd0);
    check_eq("csrrs_addr", 64'(c.csr_addr), 64'h300);
    check_eq("csrrs_rd",   64'(c.rd),       64'd10);
    decode_one(32'h3000_1073, c);
    check_eq("csrrw_write", 64'(c.csr_write), 64'd1);
    check_eq("csrrw_read",  64'(c.csr_read),  64'd0);

    // Sign extension and a bad branch funct3
    decode_one(32'hfff0_0113, c);
    check_eq("addi_neg_imm", 64'(c.imm), 64'hffff_ffff);
    decode_one(32'h1234_50b7, c);
    check_eq("lui_imm",  64'(c.imm),       64'h1234_5000);
    check_eq("lui_zero", 64'(c.src1_zero), 64'd1);
    decode_one(32'h0000_2063, c);
    check_eq("br_bad_ill", 64'(c.illegal), 64'd1);
    check_eq("br_bad_br",  64'(c.branch),  64'd0);

    // Back-to-back with execute stalled: skid fills, order preserved
    imm_q.delete();
    pc_q.delete();
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = addi_x1(12'd1);
    step();
    check_eq("skid_rdy1", 64'(bus.in_ready), 64'd1);
    bus.in_instr = addi_x1(12'd2);
    step();
    check_eq("skid_rdy2", 64'(bus.in_ready),     64'd0);
    check_eq("skid_head", 64'(bus.out_ctrl.imm), 64'd1);
    bus.in_instr = addi_x1(12'd3);
    step();
    check_eq("skid_rdy3", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    step();
    check_eq("skid_rdy4",  64'(bus.in_ready),     64'd1);
    check_eq("skid_head2", 64'(bus.out_ctrl.imm), 64'd2);
    step();
    bus.in_instr = addi_x1(12'd4);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    check_eq("skid_count", 64'(imm_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("skid_order%0d", i),
               64'((i < imm_q.size()) ? imm_q[i] : 32'hdead_beef), 64'(i + 1));
    end

    // Flush while in SKID drops held and incoming entries
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = addi_x1(12'd7);
    bus.in_pc     = 32'h40;
    step();
    bus.in_instr = addi_x1(12'd8);
    bus.in_pc    = 32'h44;
    step();
    check_eq("flush_pre_rdy", 64'(bus.in_ready), 64'd0);
    flush        = 1'b1;
    bus.in_instr = addi_x1(12'd9);
    bus.in_pc    = 32'h48;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check_eq("flush_vld", 64'(bus.out_valid), 64'd0);
    check_eq("flush_rdy", 64'(bus.in_ready),  64'd1);
    imm_q.delete();
    pc_q.delete();
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = addi_x1(12'h10);
    bus.in_pc     = 32'h100;
    step();
    bus.in_valid = 1'b0;
    check_eq("post_flush_pc",  64'(bus.out_pc),       64'h100);
    check_eq("post_flush_imm", 64'(bus.out_ctrl.imm), 64'h10);
    step();
    step();
    check_eq("post_flush_cnt", 64'(pc_q.size()), 64'd1);
    check_eq("post_flush_q",   64'((pc_q.size() > 0) ? pc_q[0] : 32'hdead_beef), 64'h100);

    // Reset while holding an instruction
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = addi_x1(12'd3);
    bus.in_pc     = 32'h80;
    step();
    bus.in_valid = 1'b0;
    check_eq("mid_pre_vld", 64'(bus.out_valid), 64'd1);
    rst_b = 1'b0;
    step();
    check_eq("mid_rst_vld", 64'(bus.out_valid), 64'd0);
    check_eq("mid_rst_pc",  64'(bus.out_pc),    64'd0);
    check_eq("mid_rst_rdy", 64'(bus.in_ready),  64'd1);
    rst_b = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
